dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the 5-stage RISC-V core: the memory-side end of the core's load/store interface. It accepts one load or store request per transaction over a valid/ready handshake and inserts a programmable number of wait states. It steers byte lanes and sign/zero-extends per RISC-V funct3, then returns one response, with an error flag, over a second valid/ready handshake. It replaces the zero-latency combinational data memory whenever the pipeline must tolerate slow memory.

## Interface
- DEPTH_WORDS, 1024: number of 32-bit words, power of two, at least 2.
- WAIT_CYCLES, 2: wait states inserted before each access, 0..15.
- clk  input  1: single clock, rising edge.
- rst  input  1: reset, synchronous and active-low (rst=0 resets on the rising clk edge).
- req_valid  input  1: request present.
- req_ready  output  1: responder accepts a request this cycle.
- req_write  input  1: 1 = store, 0 = load.
- req_funct3  input  3: RISC-V funct3 of the load/store.
- req_addr  input  32: byte address.
- req_wdata  input  32: store data, right-aligned (rs2 value).
- rsp_valid  output  1: response present.
- rsp_ready  input  1: requester takes the response.
- rsp_rdata  output  32: extended load data; 0 for stores and errors.
- rsp_err  output  1: request rejected; no memory side effect.
- busy  output  1: high in every state except IDLE.

## Operation
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE: req_ready=1.
  - Acceptance happens on an edge with req_valid=1.
  - On acceptance, write, funct3, addr and wdata are latched and the wait counter is loaded with WAIT_CYCLES.
  - Next state is WAIT, or ACCESS directly if WAIT_CYCLES=0.
- WAIT: the counter decrements each cycle; at 1 the FSM moves to ACCESS.
- ACCESS: a single cycle.
  - The error check runs first.
  - A store performs its byte-enabled write on the exit edge.
  - A load registers its extended data on the exit edge.
  - Next state is RESP.
- RESP: rsp_valid=1; rsp_rdata and rsp_err hold stable until an edge with rsp_ready=1. That edge returns the FSM to IDLE.
- req_ready is 0 in WAIT, ACCESS and RESP. Transactions never overlap.
- Loads:
  - LB 000 and LBU 100: byte lane addr[1:0].
  - LH 001 and LHU 101: halfword lane addr[1].
  - LW 010: full word.
  - LB and LH sign-extend; LBU and LHU zero-extend.
- Stores:
  - SB 000: byte enable 1<<addr[1:0], data wdata[7:0] replicated on all lanes.
  - SH 001: byte enable 0011 or 1100 by addr[1], data wdata[15:0] replicated.
  - SW 010: byte enable 1111.
- Word index is addr[2 +: log2(DEPTH_WORDS)].
- rsp_err=1 whenever any of the following holds:
  - req_addr >= 4*DEPTH_WORDS.
  - funct3 is illegal for the direction (loads 011/110/111; stores anything other than 000/001/010).
  - The access is misaligned and the misalign trap is compiled in (see Configuration).
- When rsp_err=1, nothing is written and rsp_rdata=0.
- Memory contents are not reset and are undefined until written.

## Timing
- Reset values: req_ready=0 while rst=0 and 1 in the first cycle after release; rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0; state IDLE; counter 0.
- Latency: with acceptance edge t0, rsp_valid first goes high after edge t0+WAIT_CYCLES+1.
- Minimum transaction period: WAIT_CYCLES+2 cycles (the RESP cycle is taken immediately).
- Reset mid-operation: reset has priority on any edge.
  - A store in WAIT is discarded.
  - A store whose ACCESS exit edge coincides with rst=0 does not write.
  - A pending response is dropped.
- rsp_ready asserted outside RESP is ignored. req_valid outside IDLE is ignored and the request is not latched.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined:
  - LH, LHU and SH with addr[0]=1 give rsp_err=1.
  - LW and SW with addr[1:0]!=0 give rsp_err=1.
  - No write occurs on these errors.
- DMEM_MISALIGN_TRAP_EN undefined:
  - Low address bits that the access size does not use are ignored (halfword ignores addr[0]; word ignores addr[1:0]).
  - The access proceeds aligned with rsp_err=0.

## Structure
- Package dmem_pkg holds:
  - the funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the state enum dmem_state_e;
  - the function that computes the misalign/illegal check.
- Sub-module dmem_lane_unit is purely combinational. It turns latched addr, funct3 and wdata into the byte-enable and write-data lanes, and turns the read word into the extended load data.
- The array, FSM and counter stay in dmem_responder.

## Test plan
- WAIT_CYCLES=2: SW 0x876543A1 to 0x8, then LW 0x8.
  - rsp_valid rises 3 edges after each acceptance.
  - The load returns 0x876543A1 with rsp_err=0.
- Sign and zero extension on that word:
  - LB 0x8 returns 0xFFFFFFA1; LBU 0x8 returns 0x000000A1.
  - LH 0xA returns 0xFFFF8765; LHU 0xA returns 0x00008765.
- SB 0x5C to 0x9, then LW 0x8 returns 0x87655CA1. SH 0x1234 to 0xA, then LW returns 0x12345CA1.
- Macro defined: LW 0x6 returns rsp_err=1, rdata 0. SW to 0x1000 (DEPTH_WORDS=1024) returns err and memory is unchanged. Macro undefined: LW 0x6 returns the word at 0x4 with err=0.
- Hold rsp_ready=0 for 5 cycles in RESP: rsp_valid, rdata and err stay stable and req_ready stays 0. The FSM returns to IDLE on the first edge with rsp_ready=1.
- Assert rst=0 during WAIT of SW 0xDEADBEEF to 0x10: all outputs take their reset values, and a later LW 0x10 returns the value stored there before the interrupted SW.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared funct3 codes, FSM state type and the request error check
// for the data-memory responder.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } dmem_state_e;

    // Reject out-of-range addresses, funct3 codes illegal for the direction,
    // and (when trap_en is set) misaligned halfword/word accesses.
    function automatic logic dmem_req_err(
        input logic        write,
        input logic [2:0]  funct3,
        input logic [31:0] addr,
        input logic [32:0] addr_limit,
        input logic        trap_en
    );
        logic illegal_s;
        logic misal_s;
        if (write) begin
            case (funct3)
                F3_B, F3_H, F3_W: illegal_s = 1'b0;
                default:          illegal_s = 1'b1;
            endcase
        end else begin
            case (funct3)
                F3_B, F3_H, F3_W, F3_BU, F3_HU: illegal_s = 1'b0;
                default:                        illegal_s = 1'b1;
            endcase
        end
        case (funct3)
            F3_H, F3_HU: misal_s = addr[0];
            F3_W:        misal_s = (addr[1:0] != 2'b00);
            default:     misal_s = 1'b0;
        endcase
        return ({1'b0, addr} >= addr_limit) || illegal_s || (trap_en && misal_s);
    endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// dmem_lane_unit: combinational byte-lane steering. Produces store byte
// enables and replicated write lanes, and extracts/extends load data.
module dmem_lane_unit
    import dmem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wlanes,
    output logic [31:0] rdata_ext
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    assign byte_s = rword[{addr_lo, 3'b000} +: 8];
    assign half_s = addr_lo[1] ? rword[31:16] : rword[15:0];

    // Store side: byte enables from size/offset, data replicated across lanes.
    always_comb begin
        be     = 4'b0000;
        wlanes = 32'h0000_0000;
        case (funct3)
            F3_B: begin
                be     = 4'b0001 << addr_lo;
                wlanes = {4{wdata[7:0]}};
            end
            F3_H: begin
                be     = addr_lo[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{wdata[15:0]}};
            end
            F3_W: begin
                be     = 4'b1111;
                wlanes = wdata;
            end
            default: begin
                be     = 4'b0000;
                wlanes = 32'h0000_0000;
            end
        endcase
    end

    // Load side: pick the lane and sign- or zero-extend by funct3.
    always_comb begin
        rdata_ext = 32'h0000_0000;
        case (funct3)
            F3_B:    rdata_ext = {{24{byte_s[7]}}, byte_s};
            F3_BU:   rdata_ext = {24'h00_0000, byte_s};
            F3_H:    rdata_ext = {{16{half_s[15]}}, half_s};
            F3_HU:   rdata_ext = {16'h0000, half_s};
            F3_W:    rdata_ext = rword;
            default: rdata_ext = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder with programmable wait states,
// valid/ready request and response handshakes, byte-lane steering and
// an error flag. Optional feature macro: DMEM_MISALIGN_TRAP_EN (misaligned
// halfword/word accesses are rejected instead of being silently aligned).
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int          AW         = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_INIT  = 4'(WAIT_CYCLES);
    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;
`ifdef DMEM_MISALIGN_TRAP_EN
    localparam logic        TRAP_EN    = 1'b1;
`else
    localparam logic        TRAP_EN    = 1'b0;
`endif

    dmem_state_e state_r;
    dmem_state_e state_s;
    logic [3:0]  cnt_r;
    logic        write_r;
    logic [2:0]  funct3_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic        req_ready_r;
    logic        rsp_valid_r;
    logic [31:0] rsp_rdata_r;
    logic        rsp_err_r;
    logic        busy_r;

    logic          accept_s;
    logic          err_s;
    logic [AW-1:0] idx_s;
    logic [31:0]   rword_s;
    logic [3:0]    be_s;
    logic [31:0]   wlanes_s;
    logic [31:0]   load_s;

    logic [31:0] mem_r [DEPTH_WORDS];

    // Acceptance needs the registered ready so nothing is taken while it reads 0.
    assign accept_s = (state_r == ST_IDLE) && req_ready_r && req_valid;
    assign err_s    = dmem_req_err(write_r, funct3_r, addr_r, ADDR_LIMIT, TRAP_EN);
    assign idx_s    = addr_r[2 +: AW];
    assign rword_s  = mem_r[idx_s];

    dmem_lane_unit u_lane (
        .addr_lo   (addr_r[1:0]),
        .funct3    (funct3_r),
        .wdata     (wdata_r),
        .rword     (rword_s),
        .be        (be_s),
        .wlanes    (wlanes_s),
        .rdata_ext (load_s)
    );

    // Next-state logic for the transaction FSM.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = (WAIT_INIT == 4'd0) ? ST_ACCESS : ST_WAIT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r <= 4'd1) begin
                    state_s = ST_ACCESS;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_ACCESS: state_s = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register plus handshake/busy outputs registered from next state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            req_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            req_ready_r <= (state_s == ST_IDLE);
            rsp_valid_r <= (state_s == ST_RESP);
            busy_r      <= (state_s != ST_IDLE);
        end
    end

    // Latch the request on acceptance and run the wait-state counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_r    <= 4'd0;
            write_r  <= 1'b0;
            funct3_r <= 3'b000;
            addr_r   <= 32'h0000_0000;
            wdata_r  <= 32'h0000_0000;
        end else if (accept_s) begin
            cnt_r    <= WAIT_INIT;
            write_r  <= req_write;
            funct3_r <= req_funct3;
            addr_r   <= req_addr;
            wdata_r  <= req_wdata;
        end else if ((state_r == ST_WAIT) && (cnt_r != 4'd0)) begin
            cnt_r <= cnt_r - 4'd1;
        end
    end

    // Capture the response at ACCESS exit; clear it once it is consumed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rsp_rdata_r <= 32'h0000_0000;
            rsp_err_r   <= 1'b0;
        end else if (state_r == ST_ACCESS) begin
            rsp_err_r   <= err_s;
            rsp_rdata_r <= (write_r || err_s) ? 32'h0000_0000 : load_s;
        end else if ((state_r == ST_RESP) && rsp_ready) begin
            rsp_rdata_r <= 32'h0000_0000;
            rsp_err_r   <= 1'b0;
        end
    end

    // Byte-enabled store on ACCESS exit; suppressed by error or reset.
    always_ff @(posedge clk) begin
        if (rst && (state_r == ST_ACCESS) && write_r && !err_s) begin
            for (int b = 0; b < 4; b++) begin
                if (be_s[b]) begin
                    mem_r[idx_s][8*b +: 8] <= wlanes_s[8*b +: 8];
                end
            end
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed vector table, back-pressure and reset
// sequences, then randomized transactions against a byte-array model.
module tb_dmem_responder;

    localparam int DEPTH = 1024;
    localparam int WAITC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] ref_mem [64];

    typedef struct {
        logic        w;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vq[$];

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic addv(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] er, input logic ee);
        vec_t v;
        v.w = w; v.f3 = f3; v.addr = a; v.wdata = wd; v.exp_rdata = er; v.exp_err = ee;
        vq.push_back(v);
    endtask

    // Present a request and complete its acceptance edge.
    task automatic start_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd);
        int n;
        n = 0;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        if (!req_ready) check("req_ready_timeout", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
        tick();
        req_valid = 1'b0;
        req_wdata = 32'hA5A5_5A5A;
    endtask

    // Count edges after acceptance until rsp_valid appears.
    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            tick();
            lat++;
        end
    endtask

    task automatic do_txn(input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int hold, input string tag,
                          output logic [31:0] rd, output logic er);
        int lat;
        start_req(w, f3, a, wd);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        wait_rsp(lat);
        check({tag, "_latency"}, 32'(lat), 32'(WAITC + 1));
        for (int i = 0; i < hold; i++) tick();
        rd = rsp_rdata;
        er = rsp_err;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    // Reference behaviour computed from size/offset rules over a byte array.
    task automatic model(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] er_d, output logic ee);
        int unsigned size;
        int unsigned base;
        bit legal;
        bit sgn;
        longint unsigned v;
        legal = 1'b1; sgn = 1'b0; size = 1;
        if (w) begin
            if (f3 == 3'd0) size = 1; else if (f3 == 3'd1) size = 2;
            else if (f3 == 3'd2) size = 4; else legal = 1'b0;
        end else begin
            if (f3 == 3'd0 || f3 == 3'd4) size = 1;
            else if (f3 == 3'd1 || f3 == 3'd5) size = 2;
            else if (f3 == 3'd2) size = 4;
            else legal = 1'b0;
            sgn = (f3 == 3'd0 || f3 == 3'd1);
        end
        ee = !legal || (a >= 32'(4 * DEPTH));
`ifdef DMEM_MISALIGN_TRAP_EN
        if (legal && (a % size) != 0) ee = 1'b1;
`endif
        er_d = 32'h0;
        if (!ee) begin
            base = a - (a % size);
            if (w) begin
                for (int i = 0; i < int'(size); i++) ref_mem[base + i] = wd[8*i +: 8];
            end else begin
                v = 0;
                for (int i = 0; i < int'(size); i++) v = v | (longint'(ref_mem[base + i]) << (8 * i));
                if (sgn && v[8*size-1]) v = v | ~((64'd1 << (8 * size)) - 64'd1);
                er_d = v[31:0];
            end
        end
    endtask

    initial begin
        logic [31:0] rd, exp_d;
        logic        er, exp_e;
        int          lat;

        // Reset values
        tick(); tick();
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        tick();
        check("post_rst_req_ready", 32'(req_ready), 32'd1);
        check("post_rst_busy", 32'(busy), 32'd0);

        // Directed vector table
        addv(1'b1, 3'b010, 32'h0,    32'h0BAD_F00D, 32'h0, 1'b0);
        addv(1'b1, 3'b010, 32'h4,    32'h4433_2211, 32'h0, 1'b0);
        addv(1'b1, 3'b010, 32'h8,    32'h8765_43A1, 32'h0, 1'b0);
        addv(1'b0, 3'b010, 32'h8,    32'h0, 32'h8765_43A1, 1'b0);
        addv(1'b0, 3'b000, 32'h8,    32'h0, 32'hFFFF_FFA1, 1'b0);
        addv(1'b0, 3'b100, 32'h8,    32'h0, 32'h0000_00A1, 1'b0);
        addv(1'b0, 3'b001, 32'hA,    32'h0, 32'hFFFF_8765, 1'b0);
        addv(1'b0, 3'b101, 32'hA,    32'h0, 32'h0000_8765, 1'b0);
        addv(1'b1, 3'b000, 32'h9,    32'h0000_005C, 32'h0, 1'b0);
        addv(1'b0, 3'b010, 32'h8,    32'h0, 32'h8765_5CA1, 1'b0);
        addv(1'b1, 3'b001, 32'hA,    32'h0000_1234, 32'h0, 1'b0);
        addv(1'b0, 3'b010, 32'h8,    32'h0, 32'h1234_5CA1, 1'b0);
`ifdef DMEM_MISALIGN_TRAP_EN
        addv(1'b0, 3'b010, 32'h6,    32'h0, 32'h0, 1'b1);
        addv(1'b0, 3'b001, 32'h9,    32'h0, 32'h0, 1'b1);
`else
        addv(1'b0, 3'b010, 32'h6,    32'h0, 32'h4433_2211, 1'b0);
        addv(1'b0, 3'b001, 32'h9,    32'h0, 32'h0000_5CA1, 1'b0);
`endif
        addv(1'b1, 3'b010, 32'h1000, 32'hFFFF_FFFF, 32'h0, 1'b1);
        addv(1'b0, 3'b010, 32'h0,    32'h0, 32'h0BAD_F00D, 1'b0);
        addv(1'b0, 3'b010, 32'h1000, 32'h0, 32'h0, 1'b1);
        addv(1'b0, 3'b011, 32'h0,    32'h0, 32'h0, 1'b1);
        addv(1'b1, 3'b100, 32'h0,    32'h1111_1111, 32'h0, 1'b1);
        addv(1'b0, 3'b010, 32'h0,    32'h0, 32'h0BAD_F00D, 1'b0);
        for (int i = 0; i < vq.size(); i++) begin
            do_txn(vq[i].w, vq[i].f3, vq[i].addr, vq[i].wdata, 0, $sformatf("vec%0d", i), rd, er);
            check($sformatf("vec%0d_rdata", i), rd, vq[i].exp_rdata);
            check($sformatf("vec%0d_err", i), 32'(er), 32'(vq[i].exp_err));
        end

        // Back-pressure: response held stable for 5 cycles
        start_req(1'b0, 3'b010, 32'h8, 32'h0);
        wait_rsp(lat);
        check("hold_latency", 32'(lat), 32'(WAITC + 1));
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            check("hold_rsp_rdata", rsp_rdata, 32'h1234_5CA1);
            check("hold_rsp_err", 32'(rsp_err), 32'd0);
            check("hold_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("hold_release_valid", 32'(rsp_valid), 32'd0);
        check("hold_release_ready", 32'(req_ready), 32'd1);

        // Reset during WAIT of a store
        do_txn(1'b1, 3'b010, 32'h10, 32'h1122_3344, 0, "pre_rst", rd, er);
        start_req(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
        rst = 1'b0;
        tick();
        check("midrst_req_ready", 32'(req_ready), 32'd0);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_rsp_rdata", rsp_rdata, 32'd0);
        check("midrst_rsp_err", 32'(rsp_err), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        tick();
        check("midrst_ready_after", 32'(req_ready), 32'd1);
        do_txn(1'b0, 3'b010, 32'h10, 32'h0, 0, "midrst_ld", rd, er);
        check("midrst_ld_rdata", rd, 32'h1122_3344);

        // Reset coinciding with the ACCESS exit edge of a store
        start_req(1'b1, 3'b010, 32'h10, 32'hCAFE_BABE);
        tick();
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        do_txn(1'b0, 3'b010, 32'h10, 32'h0, 0, "accrst_ld", rd, er);
        check("accrst_ld_rdata", rd, 32'h1122_3344);

        // Randomized phase: seed a 64-byte window, then mixed traffic
        for (int wi = 0; wi < 16; wi++) begin
            logic [31:0] val;
            val = $urandom;
            model(1'b1, 3'b010, 32'(wi * 4), val, exp_d, exp_e);
            do_txn(1'b1, 3'b010, 32'(wi * 4), val, 0, "seed", rd, er);
            check("seed_err", 32'(er), 32'(exp_e));
        end
        for (int t = 0; t < 150; t++) begin
            logic        w;
            logic [2:0]  f3;
            logic [31:0] a, wd;
            int          l;
            w = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) f3 = 3'($urandom_range(0, 7));
            else if (w) f3 = 3'($urandom_range(0, 2));
            else begin
                l = $urandom_range(0, 4);
                f3 = (l < 3) ? 3'(l) : 3'(l + 1);
            end
            if ($urandom_range(0, 9) == 0) a = 32'h1000 + 32'($urandom_range(0, 255));
            else a = 32'($urandom_range(0, 63));
            wd = $urandom;
            model(w, f3, a, wd, exp_d, exp_e);
            do_txn(w, f3, a, wd, $urandom_range(0, 2), "rnd", rd, er);
            check($sformatf("rnd%0d_rdata", t), rd, exp_d);
            check($sformatf("rnd%0d_err", t), 32'(er), 32'(exp_e));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
